// File: rtl/mem_bus_ctrl.sv
// M-stage load/store bus controller: alignment check, lane steering, req/ack.
// Optional REQ timeout abort: define MEM_TIMEOUT_EN.
module mem_bus_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  LS_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata_word,
   output logic        adel,
   output logic        ades,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] LS_W = 2'b00;
   localparam logic [1:0] LS_H = 2'b01;
   localparam logic [1:0] LS_B = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        squash_q, squash_d;
   logic        bus_err_q, bus_err_d;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC) : 8;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

   logic        misalign;
   logic [3:0]  be_new;
   logic [31:0] wd_new;
   logic        is_idle;
   logic        accept;

   // Size decode: alignment, byte enables and lane-replicated store data
   always_comb begin
      misalign = 1'b0;
      be_new   = 4'b1111;
      wd_new   = wdata;
      case (LS_op)
         LS_H: begin
            misalign = addr[0];
            be_new   = addr[1] ? 4'b1100 : 4'b0011;
            wd_new   = {2{wdata[15:0]}};
         end
         LS_B: begin
            be_new = 4'b0001 << addr[1:0];
            wd_new = {4{wdata[7:0]}};
         end
         default: begin
            misalign = (addr[1:0] != 2'b00);
         end
      endcase
   end

   assign is_idle = (state_q == S_IDLE);
   assign accept  = is_idle & req_valid & ~flush & ~misalign;

   // Next-state and bus register updates
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      squash_d    = squash_q;
      bus_err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d     = S_REQ;
               bus_req_d   = 1'b1;
               bus_we_d    = req_we;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_be_d    = be_new;
               bus_wdata_d = wd_new;
`ifdef MEM_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         S_REQ: begin
            if (flush) begin
               squash_d = 1'b1;
            end
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = S_DONE;
               if (!bus_we_q && !squash_q && !flush) begin
                  rdata_d = bus_rdata;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            // Never re-accept the instruction still sitting in M
            state_d  = S_IDLE;
            squash_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
         squash_q    <= 1'b0;
         bus_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         squash_q    <= squash_d;
         bus_err_q   <= bus_err_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign stall = reset_n & (accept | (state_q == S_REQ));
   assign adel  = reset_n & is_idle & req_valid & ~flush & misalign & ~req_we;
   assign ades  = reset_n & is_idle & req_valid & ~flush & misalign & req_we;
   assign done  = (state_q == S_DONE) & ~squash_q & ~flush & ~bus_err_q;

   assign rdata_word = rdata_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;
`ifdef MEM_TIMEOUT_EN
   assign bus_err    = bus_err_q;
`else
   assign bus_err    = 1'b0;
`endif

endmodule
